// File: rtl/overlay_char_scanout.sv
// Overlay character scan-out: fetches char codes and font rows one cell ahead of the raster and emits a per-pixel flag.
// Optional drop-shadow output is built only when OVERLAY_SHADOW_EN is defined.
module overlay_char_scanout #(
    parameter int COLS  = 32,
    parameter int ROWS  = 30,
    parameter int H_ORG = 64,
    parameter int V_ORG = 48
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        i_pix,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    output logic [10:0] chram_addr,
    input  logic [7:0]  chmap_data,
    output logic [10:0] chrom_addr,
    input  logic [7:0]  chrom_data,
    output logic        o_a,
    output logic        o_shadow
);
    typedef enum logic [1:0] {S_IDLE, S_MAP, S_ROM, S_LATCH} state_t;

    state_t      state, state_nxt;
    logic [9:0]  x, y, px;
    logic        inwin, trigger;
    logic [10:0] map_addr;
    logic [10:0] chrom_addr_q;
    logic [2:0]  line_q;
    logic [7:0]  next_bits, cur_bits;
    logic        load_map, load_rom, load_bits;
    logic        a_nxt;

    function automatic logic pick_bit(input logic [7:0] bits, input logic [2:0] idx);
        return bits[3'd7 - idx];
    endfunction

    // px runs 8 pixels ahead of x so each cell is fetched while the previous one is on screen
    assign x        = hcnt - 10'(H_ORG);
    assign y        = vcnt - 10'(V_ORG);
    assign px       = x + 10'd8;
    assign inwin    = (x < 10'(COLS * 8)) && (y < 10'(ROWS * 8));
    assign trigger  = i_pix && (px[2:0] == 3'd0) && ({3'd0, px[9:3]} < 10'(COLS))
                      && (y < 10'(ROWS * 8));
    assign map_addr = 11'(y[9:3]) * 11'(COLS) + 11'(px[9:3]);

    always_ff @(posedge i_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_map  = 1'b0;
        load_rom  = 1'b0;
        load_bits = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_MAP;
                    load_map  = 1'b1;
                end
            end
            S_MAP:   state_nxt = S_ROM;
            S_ROM: begin
                state_nxt = S_LATCH;
                load_rom  = 1'b1;
            end
            S_LATCH: begin
                state_nxt = S_IDLE;
                load_bits = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The char code arrives during ROM, so the font address is forwarded straight from it that cycle
    assign chrom_addr = load_rom ? {chmap_data, line_q} : chrom_addr_q;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            chram_addr   <= 11'd0;
            chrom_addr_q <= 11'd0;
            line_q       <= 3'd0;
            next_bits    <= 8'd0;
        end else begin
            if (load_map) begin
                chram_addr <= map_addr;
                line_q     <= y[2:0];
            end
            if (load_rom)  chrom_addr_q <= chrom_addr;
            if (load_bits) next_bits    <= chrom_data;
        end
    end

    always_comb begin
        a_nxt = 1'b0;
        if (inwin) begin
            if (x[2:0] == 3'd0) a_nxt = next_bits[7];
            else                a_nxt = pick_bit(cur_bits, x[2:0]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            o_a      <= 1'b0;
            cur_bits <= 8'd0;
        end else if (i_pix) begin
            o_a <= a_nxt;
            if (inwin && (x[2:0] == 3'd0)) cur_bits <= next_bits;
        end
    end

`ifdef OVERLAY_SHADOW_EN
    logic prev_a;

    // Shadow marks the clear pixel immediately right of a set one
    always_ff @(posedge i_clk) begin
        if (reset) begin
            prev_a   <= 1'b0;
            o_shadow <= 1'b0;
        end else if (i_pix) begin
            prev_a   <= a_nxt;
            o_shadow <= prev_a && !a_nxt && inwin;
        end
    end
`else
    assign o_shadow = 1'b0;
`endif

endmodule

// File: tb/tb_overlay_char_scanout.sv
// Randomized scoreboard bench for overlay_char_scanout with a cell/font-level reference model.
module tb_overlay_char_scanout;
    localparam int COLS  = 32;
    localparam int ROWS  = 30;
    localparam int H_ORG = 64;
    localparam int V_ORG = 48;
`ifdef OVERLAY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        reset;
    logic        i_pix;
    logic [9:0]  hcnt, vcnt;
    logic [10:0] chram_addr, chrom_addr;
    logic [7:0]  chmap_data, chrom_data;
    logic        o_a, o_shadow;

    overlay_char_scanout #(.COLS(COLS), .ROWS(ROWS), .H_ORG(H_ORG), .V_ORG(V_ORG)) dut (
        .i_clk(i_clk), .reset(reset), .i_pix(i_pix), .hcnt(hcnt), .vcnt(vcnt),
        .chram_addr(chram_addr), .chmap_data(chmap_data),
        .chrom_addr(chrom_addr), .chrom_data(chrom_data),
        .o_a(o_a), .o_shadow(o_shadow)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] ram [0:2047];
    logic [7:0] rom [0:2047];

    always @(posedge i_clk) begin
        chmap_data <= ram[chram_addr];
        chrom_data <= rom[chrom_addr];
    end

    typedef struct {
        bit          a;
        bit          sh;
        logic [10:0] map;
        logic [10:0] rom;
        int          h;
        int          v;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_this = 1'b0;
    bit   pend     = 1'b0;

    int   m_map = 0, m_rom = 0, rom_pend = 0;
    bit   pend_v = 1'b0, m_prev = 1'b0;

    task automatic check(input string name, input int h, input int v,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s h=%0d v=%0d: got %0h expected %0h", name, h, v, act, exp);
        end
    endtask

    function automatic bit in_win(input int x, input int y);
        return (x >= 0) && (x < COLS * 8) && (y >= 0) && (y < ROWS * 8);
    endfunction

    // Reference pixel: look up the character cell, then its font row, then the bit for the column
    function automatic bit pix_model(input int x, input int y);
        logic [7:0] code, bits;
        if (!in_win(x, y)) return 1'b0;
        code = ram[(y / 8) * COLS + x / 8];
        bits = rom[int'(code) * 8 + y % 8];
        return bits[7 - x % 8];
    endfunction

    task automatic idle();
        @(negedge i_clk);
        i_pix    = 1'b0;
        reset    = 1'b0;
        chk_this = 1'b0;
    endtask

    task automatic strobe(input int h, input int v, input bit rst, input bit ck);
        exp_t e;
        int   x, y, px;
        bit   ea, trig;
        @(negedge i_clk);
        hcnt     = 10'(h);
        vcnt     = 10'(v);
        i_pix    = 1'b1;
        reset    = rst;
        chk_this = ck;
        x  = h - H_ORG;
        y  = v - V_ORG;
        px = x + 8;
        if (rst) begin
            ea = 1'b0; e.sh = 1'b0; m_map = 0; m_rom = 0; pend_v = 1'b0; m_prev = 1'b0;
        end else begin
            if (pend_v) begin
                m_rom  = rom_pend;
                pend_v = 1'b0;
            end
            ea   = pix_model(x, y);
            trig = (px >= 0) && (px % 8 == 0) && (px / 8 < COLS) && (y >= 0) && (y < ROWS * 8);
            if (trig) begin
                m_map    = (y / 8) * COLS + px / 8;
                rom_pend = int'(ram[m_map]) * 8 + y % 8;
                pend_v   = 1'b1;
            end
            e.sh   = SHADOW && in_win(x, y) && m_prev && !ea;
            m_prev = ea;
        end
        e.a   = ea;
        e.map = 11'(m_map);
        e.rom = 11'(m_rom);
        e.h   = h;
        e.v   = v;
        if (ck) q.push_back(e);
    endtask

    task automatic run_line(input int v, input int h0, input int h1, input int stride, input int rst_at);
        bit ck = 1'b1;
        for (int h = h0; h <= h1; h++) begin
            repeat (stride - 1) idle();
            if (h == rst_at) begin
                strobe(h, v, 1'b1, ck);
                ck = 1'b0;
            end else begin
                strobe(h, v, 1'b0, ck);
            end
        end
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 2048; i++) begin
            ram[i] = rnd ? 8'($urandom) : 8'd0;
            rom[i] = rnd ? 8'($urandom) : 8'd0;
        end
    endtask

    always @(posedge i_clk) pend <= chk_this;

    always @(negedge i_clk) begin
        if (pend) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: output with no expected entry");
            end else begin
                me = q.pop_front();
                check("o_a", me.h, me.v, 32'(o_a), 32'(me.a));
                check("o_shadow", me.h, me.v, 32'(o_shadow), 32'(me.sh));
                check("chram_addr", me.h, me.v, 32'(chram_addr), 32'(me.map));
                check("chrom_addr", me.h, me.v, 32'(chrom_addr), 32'(me.rom));
            end
        end
    end

    initial begin
        int v;
        reset = 1'b1; i_pix = 1'b0; hcnt = 10'd0; vcnt = 10'd0;
        fill(1'b1);
        repeat (3) @(negedge i_clk);
        check("reset o_a", 0, 0, 32'(o_a), 32'd0);
        check("reset o_shadow", 0, 0, 32'(o_shadow), 32'd0);
        check("reset chram_addr", 0, 0, 32'(chram_addr), 32'd0);
        check("reset chrom_addr", 0, 0, 32'(chrom_addr), 32'd0);
        reset = 1'b0;

        // Single glyph at cell 0, line 0
        fill(1'b0);
        ram[0] = 8'h41; rom[16'h41 * 8] = 8'hA5;
        run_line(48, 40, 340, 1, -1);

        // Row 10 col 11, font line 3
        fill(1'b0);
        ram[331] = 8'h2A; rom[16'h2A * 8 + 3] = 8'hC3;
        run_line(48 + 83, 40, 340, 1, -1);

        // Lone leftmost pixel at column 0
        fill(1'b0);
        ram[0] = 8'h10; rom[16'h10 * 8] = 8'h80;
        run_line(48, 40, 340, 1, -1);

        // Vertical window edges
        fill(1'b1);
        run_line(47, 40, 340, 1, -1);
        run_line(48 + 240, 40, 340, 1, -1);
        run_line(48 + 239, 40, 340, 1, -1);

        // Solid block over a full line with sparse strobes
        fill(1'b1);
        for (int i = 0; i < 2048; i++) ram[i] = 8'h7F;
        for (int i = 0; i < 8; i++) rom[16'h7F * 8 + i] = 8'hFF;
        run_line(48 + int'($urandom_range(0, 239)), 0, 1023, 3, -1);

        for (int n = 0; n < 10; n++) begin
            fill(1'b1);
            run_line(48 + int'($urandom_range(0, 239)), 40, 340, int'($urandom_range(1, 3)), -1);
        end

        // Reset during the fetch of column 8, then an undisturbed line
        fill(1'b1);
        v = 48 + int'($urandom_range(0, 239));
        run_line(v, 40, 340, 1, 121);
        run_line(v, 40, 340, 1, -1);

        repeat (4) idle();
        check("scoreboard drained", 0, 0, 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
